cart2cyl_cordic: RTL and testbench

//  Sequential, parametrised Cartesian-to-cylindrical converter: (x,y,z) -> (r,theta,z).

---
 rtl/cart2cyl_cordic_pkg.sv | 24 ++
 rtl/cart2cyl_cordic_atan_rom.sv | 29 ++
 rtl/cart2cyl_cordic.sv | 167 ++++++++++++++++
 tb/tb_cart2cyl_cordic.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart2cyl_cordic_pkg.sv
// Shared types and constants for the CORDIC Cartesian-to-cylindrical converter.
package cart2cyl_pkg;

    // Controller states; the datapath action is keyed off the current state.
    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        ITER,
        SCALE,
        DONE
    } state_t;

    // 1/K for the CORDIC vectoring gain K ~= 1.646760, as Q16 (0.607253).
    localparam int unsigned CORDIC_GAIN_INV_Q16 = 39797;

    // atan(2^-i) as a fraction of a full turn, scaled by 2^16 and rounded.
    localparam logic [15:0] ATAN_Q16 [0:15] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

endpackage

// File: rtl/cart2cyl_cordic_atan_rom.sv
// Arctangent lookup: iteration index -> atan(2^-idx) in (ANGLE_W+4)-bit binary-angle units.
module cordic_atan_rom
    import cart2cyl_pkg::*;
#(
    parameter int ANGLE_W = 8
) (
    input  logic [3:0]         idx,
    output logic [ANGLE_W+3:0] atan
);

    localparam int AW = ANGLE_W + 4;

    logic [15:0] q16;

    assign q16 = ATAN_Q16[idx];

    // The Q16 table is a full turn in 2^16 units; move it to 2^AW units.
    // Narrower angles round to nearest so the per-entry error stays below half an LSB.
    generate
        if (AW >= 16) begin : g_up
            assign atan = AW'(q16) << (AW - 16);
        end else begin : g_down
            logic [16:0] sum;
            assign sum  = {1'b0, q16} + (17'd1 << (15 - AW));
            assign atan = AW'(sum >> (16 - AW));
        end
    endgenerate

endmodule

// File: rtl/cart2cyl_cordic.sv
// Iterative CORDIC (vectoring mode) converting (x,y,z) to (r,theta,z), one micro-rotation
// per clock, with valid/ready handshakes on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high in IDLE, and in DONE while out_ready is high, so an output accept and
// the next input accept can share a cycle. out_valid is high exactly in DONE, and r/theta/
// z_out hold still until the output transfer.
module cart2cyl_cordic
    import cart2cyl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ANGLE_W = 8,
    parameter int ITERS   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   r,
    output logic [ANGLE_W-1:0] theta,
    output logic [WIDTH-1:0]   z_out
);

    // Integer part is WIDTH+2 bits (room for -(-2^(WIDTH-1)) and the ~1.65 CORDIC gain).
    // Fractional bits below it keep the truncating shifts from biasing r and theta.
    localparam int FRAC_W = ANGLE_W + 4;
    localparam int DW     = WIDTH + 2 + FRAC_W;
    localparam int AW     = ANGLE_W + 4;
    localparam int PW     = DW + 17;
    localparam int RW     = WIDTH + 3;
    localparam logic [3:0] LAST = 4'(ITERS - 1);

    state_t state, state_nxt;

    logic [3:0]           cnt;
    logic signed [DW-1:0] xr, yr;
    logic [AW-1:0]        ang;
    logic                 zero_vec;
    logic [WIDTH-1:0]     z_cap;
    logic                 in_xfer;

    logic                 d;
    logic signed [DW-1:0] x_sh, y_sh, x_nxt, y_nxt;
    logic [AW-1:0]        atan_i, ang_nxt;

    logic [PW-1:0]        prod;
    logic [RW-1:0]        r_full;
    logic [WIDTH-1:0]     r_sat;
    logic [ANGLE_W-1:0]   theta_rnd;

    assign in_xfer = in_valid & in_ready;

    cordic_atan_rom #(
        .ANGLE_W (ANGLE_W)
    ) u_atan_rom (
        .idx  (cnt),
        .atan (atan_i)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = FOLD;
            end
            FOLD:  state_nxt = ITER;
            ITER:  if (cnt == LAST) state_nxt = SCALE;
            SCALE: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? FOLD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One micro-rotation: rotate toward the +x axis, both updates from pre-iteration values.
    always_comb begin
        d    = ~yr[DW-1];
        x_sh = xr >>> cnt;
        y_sh = yr >>> cnt;
        if (d) begin
            x_nxt   = xr + y_sh;
            y_nxt   = yr - x_sh;
            ang_nxt = ang + atan_i;
        end else begin
            x_nxt   = xr - y_sh;
            y_nxt   = yr + x_sh;
            ang_nxt = ang - atan_i;
        end
    end

    // Gain compensation with round-to-nearest, saturation, and guard-bit rounding of the angle.
    // After the fold x is non-negative and only grows, so it is treated as unsigned here.
    always_comb begin
        prod      = PW'($unsigned(xr)) * PW'(CORDIC_GAIN_INV_Q16) + (PW'(1) << (15 + FRAC_W));
        r_full    = RW'(prod >> (16 + FRAC_W));
        r_sat     = (r_full > RW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : r_full[WIDTH-1:0];
        theta_rnd = ANGLE_W'((ang + AW'(8)) >> 4);
    end

    // Datapath: capture on input transfer, then fold, iterate and scale as the FSM advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr       <= '0;
            yr       <= '0;
            ang      <= '0;
            cnt      <= '0;
            zero_vec <= 1'b0;
            z_cap    <= '0;
            r        <= '0;
            theta    <= '0;
            z_out    <= '0;
        end else begin
            if (in_xfer) begin
                xr    <= {{2{x[WIDTH-1]}}, x, {FRAC_W{1'b0}}};
                yr    <= {{2{y[WIDTH-1]}}, y, {FRAC_W{1'b0}}};
                z_cap <= z;
            end
            case (state)
                FOLD: begin
                    cnt      <= '0;
                    zero_vec <= (xr == '0) && (yr == '0);
                    if (xr[DW-1]) begin
                        xr  <= -xr;
                        yr  <= -yr;
                        ang <= {1'b1, {(AW-1){1'b0}}};
                    end else begin
                        ang <= '0;
                    end
                end
                ITER: begin
                    xr  <= x_nxt;
                    yr  <= y_nxt;
                    ang <= ang_nxt;
                    cnt <= cnt + 4'd1;
                end
                SCALE: begin
                    r     <= zero_vec ? '0 : r_sat;
                    theta <= zero_vec ? '0 : theta_rnd;
                    z_out <= z_cap;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cart2cyl_cordic.sv
// Bench for cart2cyl_cordic: directed table, backpressure/back-to-back and reset-abort
// sequences, then random traffic checked against a real-valued polar model.
module tb_cart2cyl_cordic;

    localparam int  WIDTH   = 8;
    localparam int  ANGLE_W = 8;
    localparam int  ITERS   = 8;
    localparam int  LAT     = ITERS + 2;
    localparam real PI      = 3.14159265358979;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] x         = 8'd0;
    logic [7:0] y         = 8'd0;
    logic [7:0] z         = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] r;
    logic [7:0] theta;
    logic [7:0] z_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0] exp_q[$];

    typedef struct {
        int x;
        int y;
        int z;
        int r;
        int th;
        bit exact;
    } vec_t;

    vec_t vecs[8];
    bit   rand_done;

    cart2cyl_cordic #(
        .WIDTH   (WIDTH),
        .ANGLE_W (ANGLE_W),
        .ITERS   (ITERS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .theta     (theta),
        .z_out     (z_out)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, want $finish before 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input real exp, input bit circ);
        real dlt;
        n_cmp++;
        dlt = real'(act) - exp;
        if (circ) begin
            while (dlt > 128.0) dlt -= 256.0;
            while (dlt < -128.0) dlt += 256.0;
        end
        if (dlt > 1.0 || dlt < -1.0) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0.3f +-1", name, act, exp);
        end
    endtask

    // Reference: ideal polar conversion of the captured x/y, z passed through.
    task automatic check_model(input logic [23:0] e, input logic [7:0] ra,
                               input logic [7:0] ta, input logic [7:0] za);
        int  xi, yi;
        real rm, tm;
        xi = int'($signed(e[23:16]));
        yi = int'($signed(e[15:8]));
        chk("model_z", int'(za), int'(e[7:0]));
        if (xi == 0 && yi == 0) begin
            chk("model_r_origin", int'(ra), 0);
            chk("model_theta_origin", int'(ta), 0);
        end else begin
            rm = $sqrt(real'(xi * xi + yi * yi));
            tm = $atan2(real'(yi), real'(xi)) * 128.0 / PI;
            if (tm < 0.0) tm += 256.0;
            chk_tol("model_r", int'(ra), rm, 1'b0);
            chk_tol("model_theta", int'(ta), tm, 1'b1);
        end
    endtask

    // Scoreboard: record accepted inputs, check each accepted output in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got r=%0d theta=%0d, want no output", r, theta);
                end else begin
                    check_model(exp_q.pop_front(), r, theta, z_out);
                end
            end
            if (in_valid && in_ready) exp_q.push_back({x, y, z});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a vector and hold it until accepted; scramble the inputs afterwards.
    task automatic send(input logic [7:0] xi, input logic [7:0] yi, input logic [7:0] zi,
                        output bit ok);
        int g;
        g = 0;
        x = xi;
        y = yi;
        z = zi;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        ok = in_ready;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", g);
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
            x = 8'($urandom);
            y = 8'($urandom);
            z = 8'($urandom);
        end
    endtask

    // Count cycles from the input transfer until out_valid rises (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!out_valid && cyc < 50);
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_timeout: got out_valid=0 after %0d cycles, want 1", cyc);
        end
    endtask

    initial begin
        bit   ok;
        int   cyc;
        int   g;
        bit   saw;
        logic [7:0] r0, t0, z0;

        vecs[0] = '{10, 0, 5, 10, 0, 1'b0};
        vecs[1] = '{0, 10, 5, 10, 64, 1'b0};
        vecs[2] = '{-10, 0, 5, 10, 128, 1'b0};
        vecs[3] = '{0, -10, 5, 10, 192, 1'b0};
        vecs[4] = '{7, 7, 8, 10, 32, 1'b0};
        vecs[5] = '{5, 12, 3, 13, 48, 1'b0};
        vecs[6] = '{-128, -128, 1, 181, 160, 1'b0};
        vecs[7] = '{0, 0, 9, 0, 0, 1'b1};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_theta", int'(theta), 0);
        chk("reset_z_out", int'(z_out), 0);
        rst_n = 1'b1;
        tick();

        // Directed table, out_ready high: consecutive vectors overlap accept cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'(vecs[i].x), 8'(vecs[i].y), 8'(vecs[i].z), ok);
            if (ok) begin
                wait_out(cyc);
                chk("tbl_latency", cyc, LAT);
                chk("tbl_z", int'(z_out), vecs[i].z);
                if (vecs[i].exact) begin
                    chk("tbl_r_exact", int'(r), vecs[i].r);
                    chk("tbl_theta_exact", int'(theta), vecs[i].th);
                end else begin
                    chk_tol("tbl_r", int'(r), real'(vecs[i].r), 1'b0);
                    chk_tol("tbl_theta", int'(theta), real'(vecs[i].th), 1'b1);
                end
            end
        end
        tick();

        // Backpressure: outputs frozen and no input accepted while out_ready is low.
        out_ready = 1'b0;
        send(8'd5, 8'd12, 8'd3, ok);
        wait_out(cyc);
        r0 = r;
        t0 = theta;
        z0 = z_out;
        chk_tol("bp_r", int'(r0), 13.0, 1'b0);
        chk_tol("bp_theta", int'(t0), 48.0, 1'b1);
        x = 8'd0;
        y = 8'(-10);
        z = 8'd7;
        in_valid = 1'b1;
        repeat (20) begin
            tick();
            chk("bp_stable", int'(out_valid && r == r0 && theta == t0 && z_out == z0), 1);
            chk("bp_in_ready_low", int'(in_ready), 0);
        end

        // Releasing out_ready accepts the waiting input in the same cycle.
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_out_valid_drop", int'(out_valid), 0);
        wait_out(cyc);
        chk("b2b_latency", cyc, LAT);
        chk_tol("b2b_r", int'(r), 10.0, 1'b0);
        chk_tol("b2b_theta", int'(theta), 192.0, 1'b1);
        chk("b2b_z", int'(z_out), 7);
        tick();

        // Reset while iteration 3 is pending aborts the conversion.
        send(8'd100, 8'd50, 8'd20, ok);
        repeat (4) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_r", int'(r), 0);
        chk("abort_theta", int'(theta), 0);
        chk("abort_z_out", int'(z_out), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        chk("abort_no_output", int'(saw), 0);
        send(8'd3, 8'd4, 8'd6, ok);
        wait_out(cyc);
        chk("post_reset_latency", cyc, LAT);
        chk_tol("post_reset_r", int'(r), 5.0, 1'b0);
        chk_tol("post_reset_theta", int'(theta), 37.78, 1'b1);
        chk("post_reset_z", int'(z_out), 6);
        tick();

        // Random traffic with random gaps and random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(8'($urandom), 8'($urandom), 8'($urandom), ok);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Drain outstanding conversions.
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
